// File: rtl/axistream_packet_snooper_pkg.sv
// Shared definitions for the AXI-Stream packet snooper: FSM encoding and
// elaboration-time helpers used to size lane, address and length fields.
package axistream_packet_snooper_pkg;

   typedef enum logic [1:0] {
      ST_RESYNC = 2'd0,   // waiting for a TLAST to regain packet alignment
      ST_IDLE   = 2'd1,   // aligned, next beat is the first beat of a packet
      ST_ACTIVE = 2'd2    // packet in progress, being written to memory
   } snoop_state_t;

   // Ceiling log2, returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // Lane counter width; one bit minimum so PACK=1 still has a legal vector.
   function automatic int lane_bits(input int pack);
      return (pack > 1) ? clog2(pack) : 1;
   endfunction

endpackage

// File: rtl/axistream_packet_snooper_lane_packer.sv
// Lane packer: gathers PACK stream beats into one memory word, tracks the
// current lane and accumulates the packet byte count from TKEEP.
module axistream_packet_snooper_lane_packer
   import axistream_packet_snooper_pkg::*;
#(
   parameter int SNOOP_WIDTH = 32,
   parameter int MEM_WIDTH   = 64,
   parameter int CNT_WIDTH   = 14
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     take,
   input  logic                     clear,
   input  logic                     last,
   input  logic [SNOOP_WIDTH-1:0]   data,
   input  logic [SNOOP_WIDTH/8-1:0] keep,
   output logic                     emit,
   output logic [MEM_WIDTH-1:0]     word,
   output logic [CNT_WIDTH-1:0]     total
);

   localparam int PACK   = MEM_WIDTH / SNOOP_WIDTH;
   localparam int KEEP_W = SNOOP_WIDTH / 8;
   localparam int LANE_W = lane_bits(PACK);

   logic [LANE_W-1:0]    lane;
   logic [CNT_WIDTH-1:0] count;
   logic [MEM_WIDTH-1:0] gather;

   function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KEEP_W-1:0] k);
      logic [CNT_WIDTH-1:0] n;
      n = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         n = n + CNT_WIDTH'(k[i]);
      end
      return n;
   endfunction

   // Assemble the outgoing word: earlier lanes from the gather register, the
   // current beat in its lane, and zeros above it so stale lanes never leak.
   always_comb begin
      emit  = take && (last || (lane == LANE_W'(PACK - 1)));
      total = count + popcount(keep);
      word  = '0;
      for (int i = 0; i < PACK; i++) begin
         if (LANE_W'(i) < lane) begin
            word[i*SNOOP_WIDTH +: SNOOP_WIDTH] = gather[i*SNOOP_WIDTH +: SNOOP_WIDTH];
         end else if (LANE_W'(i) == lane) begin
            word[i*SNOOP_WIDTH +: SNOOP_WIDTH] = data;
         end
      end
   end

   // Lane position and running byte count; both restart on word/packet end or drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane  <= '0;
         count <= '0;
      end else if (clear) begin
         lane  <= '0;
         count <= '0;
      end else if (take) begin
         lane  <= emit ? '0 : lane + LANE_W'(1);
         count <= last ? '0 : total;
      end
   end

   // Gather register holds partially filled lanes; lanes at or above the
   // current lane are masked on output, so it needs no reset.
   always_ff @(posedge clk) begin
      if (take && !emit) begin
         for (int i = 0; i < PACK; i++) begin
            if (LANE_W'(i) == lane) begin
               gather[i*SNOOP_WIDTH +: SNOOP_WIDTH] <= data;
            end
         end
      end
   end

endmodule

// File: rtl/axistream_packet_snooper.sv
// Passive AXI-Stream tap: copies whole packets into packet memory, packing
// several beats per word, and reports a drop when a packet cannot be stored.
module axistream_packet_snooper
   import axistream_packet_snooper_pkg::*;
#(
   parameter int SNOOP_WIDTH  = 32,
   parameter int MEM_WIDTH    = 64,
   parameter int ADDR_WIDTH   = 10,
   parameter int START_SYNCED = 0
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [SNOOP_WIDTH-1:0]                    snoop_TDATA,
   input  logic [SNOOP_WIDTH/8-1:0]                  snoop_TKEEP,
   input  logic                                      snoop_TVALID,
   input  logic                                      snoop_TREADY,
   input  logic                                      snoop_TLAST,
   input  logic                                      mem_ready,
   output logic [ADDR_WIDTH-1:0]                     wr_addr,
   output logic [MEM_WIDTH-1:0]                      wr_data,
   output logic                                      wr_en,
   output logic                                      done,
   output logic [ADDR_WIDTH+clog2(MEM_WIDTH/8):0]    byte_len,
   output logic                                      drop
);

   localparam int LEN_W = ADDR_WIDTH + clog2(MEM_WIDTH / 8) + 1;

   snoop_state_t         state;
   snoop_state_t         state_nxt;
   logic                 beat;
   logic                 take;
   logic                 drop_now;
   logic                 pkt_end;
   logic                 emit;
   logic [ADDR_WIDTH-1:0] addr;
   logic                 addr_full;   // last legal word already written
   logic [MEM_WIDTH-1:0] word;
   logic [LEN_W-1:0]     total;

   assign beat    = snoop_TVALID && snoop_TREADY;
   assign pkt_end = take && snoop_TLAST;

   axistream_packet_snooper_lane_packer #(
      .SNOOP_WIDTH (SNOOP_WIDTH),
      .MEM_WIDTH   (MEM_WIDTH),
      .CNT_WIDTH   (LEN_W)
   ) u_packer (
      .clk   (clk),
      .rst_n (rst_n),
      .take  (take),
      .clear (drop_now),
      .last  (snoop_TLAST),
      .data  (snoop_TDATA),
      .keep  (snoop_TKEEP),
      .emit  (emit),
      .word  (word),
      .total (total)
   );

   // State register; reset lands in IDLE only when the link is known aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= (START_SYNCED != 0) ? ST_IDLE : ST_RESYNC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus capture/drop decisions for the current beat.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      drop_now  = 1'b0;
      case (state)
         ST_RESYNC: begin
            if (beat && snoop_TLAST) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (beat) begin
               if (mem_ready) begin
                  take      = 1'b1;
                  state_nxt = snoop_TLAST ? ST_IDLE : ST_ACTIVE;
               end else begin
                  // Packet never started, so it is skipped silently.
                  state_nxt = snoop_TLAST ? ST_IDLE : ST_RESYNC;
               end
            end
         end
         ST_ACTIVE: begin
            if (beat) begin
               if (!mem_ready || addr_full) begin
                  drop_now  = 1'b1;
                  state_nxt = snoop_TLAST ? ST_IDLE : ST_RESYNC;
               end else begin
                  take = 1'b1;
                  if (snoop_TLAST) state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_RESYNC;
      endcase
   end

   // Word address counter; the full flag catches a packet that needs one
   // word beyond the address space instead of letting it wrap to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         addr_full <= 1'b0;
      end else if (drop_now || pkt_end) begin
         addr      <= '0;
         addr_full <= 1'b0;
      end else if (emit) begin
         if (addr == '1) addr_full <= 1'b1;
         addr <= addr + ADDR_WIDTH'(1);
      end
   end

   // Registered outputs, one cycle after the beat that completes a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
         byte_len <= '0;
         drop     <= 1'b0;
      end else begin
         wr_en    <= emit;
         done     <= pkt_end;
         drop     <= drop_now;
         byte_len <= pkt_end ? total : '0;
         if (emit) begin
            wr_addr <= addr;
            wr_data <= word;
         end
      end
   end

endmodule
